// File: rtl/fetch_decode_buffer_if.sv
// Fetch-to-decode handshake bundle for fetch_decode_buffer.
// The master modport is the pipeline side (fetch and decode). The slave modport is the buffer.
interface fetch_decode_buffer_if;
    logic [15:0] instrF;
    logic [15:0] incPCF;
    logic        errF;
    logic        validF;
    logic        readyF;
    logic        flush;
    logic        stallD;
    logic [15:0] instrD;
    logic [15:0] incPCD;
    logic        errD;
    logic        validD;
    logic [15:0] stallCount;

    modport master (
        output instrF, incPCF, errF, validF, flush, stallD,
        input  readyF, instrD, incPCD, errD, validD, stallCount
    );

    modport slave (
        input  instrF, incPCF, errF, validF, flush, stallD,
        output readyF, instrD, incPCD, errD, validD, stallCount
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Circular FIFO between fetch and decode that absorbs decode stalls and is cleared by a flush.
// Optional decode-stall counter is enabled by defining FDBUF_STALL_STATS_EN.
module fetch_decode_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input logic                  clk,
    input logic                  rst,
    fetch_decode_buffer_if.slave bus
);
    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [32:0]      storage [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic [32:0]      head;

    // readyF depends only on the count register, so stallD never reaches it combinationally
    assign bus.readyF = (count < FULL_COUNT);
    assign bus.validD = (count != '0);
    assign push       = bus.validF & bus.readyF & ~bus.flush;
    assign pop        = bus.validD & ~bus.stallD & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (bus.flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; validD masks stale slots
    always_ff @(posedge clk) begin
        if (push) storage[wrPtr] <= {bus.errF, bus.incPCF, bus.instrF};
    end

    assign head       = storage[rdPtr];
    assign bus.instrD = bus.validD ? head[15:0]  : NOP_INSTR;
    assign bus.incPCD = bus.validD ? head[31:16] : 16'h0000;
    assign bus.errD   = bus.validD ? head[32]    : 1'b0;

`ifdef FDBUF_STALL_STATS_EN
    logic [15:0] stallCnt;

    // Saturating count of edges on which decode held a valid head; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= 16'h0000;
        end else if (bus.validD && bus.stallD && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign bus.stallCount = stallCnt;
`else
    assign bus.stallCount = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_decode_buffer;
    localparam int          DEPTH = 2;
    localparam logic [15:0] NOP   = 16'h0800;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [32:0] modelQ[$];
    int          modelStall;

    fetch_decode_buffer_if bus();

    fetch_decode_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output against the model's view of the queue
    task automatic checkAll(input string tag);
        logic [32:0] front;
        logic        expValid;
        int          expStall;
        expValid = (modelQ.size() != 0);
        front    = expValid ? modelQ[0] : {1'b0, 16'h0000, NOP};
`ifdef FDBUF_STALL_STATS_EN
        expStall = modelStall;
`else
        expStall = 0;
`endif
        checkOutput({tag, ".validD"}, 32'(bus.validD), 32'(expValid));
        checkOutput({tag, ".instrD"}, 32'(bus.instrD), 32'(front[15:0]));
        checkOutput({tag, ".incPCD"}, 32'(bus.incPCD), 32'(front[31:16]));
        checkOutput({tag, ".errD"}, 32'(bus.errD), 32'(front[32]));
        checkOutput({tag, ".readyF"}, 32'(bus.readyF), 32'(modelQ.size() < DEPTH));
        checkOutput({tag, ".stallCount"}, 32'(bus.stallCount), 32'(expStall));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check
    task automatic applyStimulus(input string tag, input logic v, input logic [15:0] ins,
                                 input logic [15:0] pc, input logic er, input logic fl,
                                 input logic st);
        bit canPush;
        bit canPop;
        bus.validF = v;
        bus.instrF = ins;
        bus.incPCF = pc;
        bus.errF   = er;
        bus.flush  = fl;
        bus.stallD = st;
        canPush = v && (modelQ.size() < DEPTH);
        canPop  = (modelQ.size() != 0) && !st;
        if ((modelQ.size() != 0) && st && (modelStall < 65535)) modelStall++;
        @(posedge clk);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (canPop) void'(modelQ.pop_front());
            if (canPush) modelQ.push_back({er, pc, ins});
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        modelStall = 0;
        rst        = 1'b1;
        bus.validF = 1'b0;
        bus.instrF = 16'h0000;
        bus.incPCF = 16'h0000;
        bus.errF   = 1'b0;
        bus.flush  = 1'b0;
        bus.stallD = 1'b0;
        #12;
        rst = 1'b0;
        checkAll("reset");

        applyStimulus("single_push", 1'b1, 16'h4105, 16'h0002, 1'b0, 1'b0, 1'b0);
        checkOutput("single_head", 32'(bus.instrD), 32'h4105);
        applyStimulus("single_drain", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("single_empty", 32'(bus.instrD), 32'h0800);

        applyStimulus("fill1", 1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0, 1'b1);
        applyStimulus("fill2", 1'b1, 16'h2222, 16'h0012, 1'b0, 1'b0, 1'b1);
        checkOutput("fill_full_ready", 32'(bus.readyF), 32'h0);
        applyStimulus("fill3_reject", 1'b1, 16'h3333, 16'h0014, 1'b0, 1'b0, 1'b1);
        applyStimulus("drain1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_second", 32'(bus.instrD), 32'h2222);
        applyStimulus("drain2", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus("wrap", 1'b1, 16'hA000 + 16'(i), 16'(2 * i + 2), 1'(i == 3), 1'b0, 1'b0);
        end
        applyStimulus("wrap_drain", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        applyStimulus("flushfill1", 1'b1, 16'h7001, 16'h0020, 1'b1, 1'b0, 1'b1);
        applyStimulus("flushfill2", 1'b1, 16'h7002, 16'h0022, 1'b0, 1'b0, 1'b1);
        applyStimulus("flush_full", 1'b1, 16'h5555, 16'h0024, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_nop", 32'(bus.instrD), 32'h0800);
        applyStimulus("post_flush", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        applyStimulus("stat_push", 1'b1, 16'h6161, 16'h0030, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("stat_stall", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus("stat_flush", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        applyStimulus("arst_fill1", 1'b1, 16'h8001, 16'h0040, 1'b0, 1'b0, 1'b1);
        applyStimulus("arst_fill2", 1'b1, 16'h8002, 16'h0042, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_validD", 32'(bus.validD), 32'h0);
        checkOutput("arst_instrD", 32'(bus.instrD), 32'h0800);
        checkOutput("arst_readyF", 32'(bus.readyF), 32'h1);
        modelQ.delete();
        modelStall = 0;
        #10;
        rst = 1'b0;
        checkAll("arst_release");
        applyStimulus("arst_first_push", 1'b1, 16'h9001, 16'h0050, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          1'($urandom_range(0, 9) < 7),
                          16'($urandom()), 16'($urandom()),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
